// File: rtl/ov_7670_stream_gen.sv
// OV7670 parallel-bus transmitter: drives PCLK/VSYNC/HREF/DATA with VGA-style
// RGB565 timing and a selectable test pattern (solid, bars, gradient, checker).
// All timing state advances on "ticks" (the clk edge where pclk falls), so the
// bus is stable on every pclk rising edge.
// Optional: define OV_GEN_ROW_TAG_EN to replace pixel 0 of every active line
// with {frame_cnt[5:0], y[9:0]} for line-order / dropped-frame checking.
module ov_7670_stream_gen #(
  parameter int          H_ACTIVE    = 640,
  parameter int          H_BLANK     = 144,
  parameter int          V_ACTIVE    = 480,
  parameter int          VSYNC_LINES = 3,
  parameter int          V_BACK      = 17,
  parameter int          V_FRONT     = 10,
  parameter logic [15:0] SOLID_COLOR = 16'hF800
) (
  input  logic        clk_25_2m,
  input  logic        reset,
  input  logic        enable,
  input  logic [1:0]  pattern_sel,
  output logic        pclk,
  output logic        vsync,
  output logic        href,
  output logic [7:0]  data,
  output logic        frame_done,
  output logic [15:0] frame_cnt
);

  localparam logic [11:0] H_LAST   = 12'(2*(H_ACTIVE+H_BLANK)-1);
  localparam logic [11:0] H_ACT_B  = 12'(2*H_ACTIVE);
  localparam logic [9:0]  VS_LAST  = 10'(VSYNC_LINES-1);
  localparam logic [9:0]  VB_LAST  = 10'(V_BACK-1);
  localparam logic [9:0]  VA_LAST  = 10'(V_ACTIVE-1);
  localparam logic [9:0]  VF_LAST  = 10'(V_FRONT-1);
  localparam logic [8:0]  BAR_LAST = 9'(H_ACTIVE/8-1);

  typedef enum logic [2:0] {S_IDLE, S_VSYNC, S_VBACK, S_ACTIVE, S_VFRONT} state_t;

  state_t      r_state, w_next;
  logic        r_pclk;
  logic [11:0] r_h_cnt;
  logic [9:0]  r_v_cnt;
  logic [1:0]  r_pat;
  logic [2:0]  r_bar;
  logic [8:0]  r_bar_px;
  logic        r_frame_done;
  logic [15:0] r_frame_cnt;

  logic        w_tick, w_line_end, w_last_line;
  logic        w_frame_start, w_frame_end;
  logic        w_vsync, w_href;
  logic [15:0] w_bar_color, w_pix;

  assign w_tick        = r_pclk;
  assign w_line_end    = w_tick && (r_h_cnt == H_LAST);
  assign w_frame_start = (w_next == S_VSYNC) && (r_state != S_VSYNC);
  assign w_frame_end   = w_line_end && w_last_line && (r_state == S_VFRONT);

  // pclk free-runs at half the system clock whenever out of reset
  always_ff @(posedge clk_25_2m) begin
    if (!reset) r_pclk <= 1'b0;
    else        r_pclk <= ~r_pclk;
  end

  // state register
  always_ff @(posedge clk_25_2m) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // last line of the current vertical region
  always_comb begin
    w_last_line = 1'b0;
    case (r_state)
      S_VSYNC:  w_last_line = (r_v_cnt == VS_LAST);
      S_VBACK:  w_last_line = (r_v_cnt == VB_LAST);
      S_ACTIVE: w_last_line = (r_v_cnt == VA_LAST);
      S_VFRONT: w_last_line = (r_v_cnt == VF_LAST);
      default:  w_last_line = 1'b0;
    endcase
  end

  // next-state: regions advance at the end of their last line; a frame always runs to completion
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_tick && enable)            w_next = S_VSYNC;
      S_VSYNC:  if (w_line_end && w_last_line)   w_next = S_VBACK;
      S_VBACK:  if (w_line_end && w_last_line)   w_next = S_ACTIVE;
      S_ACTIVE: if (w_line_end && w_last_line)   w_next = S_VFRONT;
      S_VFRONT: if (w_line_end && w_last_line)   w_next = enable ? S_VSYNC : S_IDLE;
      default:                                   w_next = S_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    w_vsync = (r_state == S_VSYNC);
    w_href  = (r_state == S_ACTIVE) && (r_h_cnt < H_ACT_B);
  end

  // byte and line counters; line counter restarts at each region boundary
  always_ff @(posedge clk_25_2m) begin
    if (!reset) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (w_tick) begin
      if (r_state == S_IDLE) begin
        r_h_cnt <= '0;
        r_v_cnt <= '0;
      end else if (w_line_end) begin
        r_h_cnt <= '0;
        r_v_cnt <= w_last_line ? 10'd0 : r_v_cnt + 10'd1;
      end else begin
        r_h_cnt <= r_h_cnt + 12'd1;
      end
    end
  end

  // pattern latched at every frame start; frame_done pulse and completed-frame count
  always_ff @(posedge clk_25_2m) begin
    if (!reset) begin
      r_pat        <= '0;
      r_frame_done <= 1'b0;
      r_frame_cnt  <= '0;
    end else begin
      r_frame_done <= w_frame_end;
      if (w_frame_end)   r_frame_cnt <= r_frame_cnt + 16'd1;
      if (w_frame_start) r_pat       <= pattern_sel;
    end
  end

  // colour-bar tracker: counts pixels within a bar instead of dividing x
  always_ff @(posedge clk_25_2m) begin
    if (!reset) begin
      r_bar    <= '0;
      r_bar_px <= '0;
    end else if (w_tick) begin
      if (!w_href) begin
        r_bar    <= '0;
        r_bar_px <= '0;
      end else if (r_h_cnt[0]) begin
        if (r_bar_px == BAR_LAST) begin
          r_bar_px <= '0;
          r_bar    <= r_bar + 3'd1;
        end else begin
          r_bar_px <= r_bar_px + 9'd1;
        end
      end
    end
  end

  // bar colour lookup
  always_comb begin
    case (r_bar)
      3'd0:    w_bar_color = 16'hFFFF;
      3'd1:    w_bar_color = 16'hFFE0;
      3'd2:    w_bar_color = 16'h07FF;
      3'd3:    w_bar_color = 16'h07E0;
      3'd4:    w_bar_color = 16'hF81F;
      3'd5:    w_bar_color = 16'hF800;
      3'd6:    w_bar_color = 16'h001F;
      default: w_bar_color = 16'h0000;
    endcase
  end

  // pixel value for the current x (= h_cnt>>1) and y (= active line)
  always_comb begin
    w_pix = SOLID_COLOR;
    case (r_pat)
      2'd1:    w_pix = w_bar_color;
      2'd2:    w_pix = {r_h_cnt[5:1], r_v_cnt[5:0], r_frame_cnt[4:0]};
      2'd3:    w_pix = (r_h_cnt[4] ^ r_v_cnt[3]) ? 16'hFFFF : 16'h0000;
      default: w_pix = SOLID_COLOR;
    endcase
`ifdef OV_GEN_ROW_TAG_EN
    if (r_h_cnt[11:1] == 11'd0) w_pix = {r_frame_cnt[5:0], r_v_cnt};
`endif
  end

  assign pclk       = r_pclk;
  assign vsync      = w_vsync;
  assign href       = w_href;
  assign data       = w_href ? (r_h_cnt[0] ? w_pix[7:0] : w_pix[15:8]) : 8'h00;
  assign frame_done = r_frame_done;
  assign frame_cnt  = r_frame_cnt;

endmodule

// File: tb/tb_ov_7670_stream_gen.sv
// Directed bench for ov_7670_stream_gen using two small-geometry instances:
// A (8x3 active, 20-tick lines, 6-line frames) and B (16x16 active, 36-tick lines).
module tb_ov_7670_stream_gen;

  logic        clk, reset, enable;
  logic [1:0]  pattern_sel;
  logic        pclk_a, vsync_a, href_a, fd_a;
  logic [7:0]  data_a;
  logic [15:0] fc_a;
  logic        pclk_b, vsync_b, href_b, fd_b;
  logic [7:0]  data_b;
  logic [15:0] fc_b;

  int total = 0;
  int bad   = 0;

  ov_7670_stream_gen #(.H_ACTIVE(8), .H_BLANK(2), .V_ACTIVE(3), .VSYNC_LINES(1),
                       .V_BACK(1), .V_FRONT(1)) u_a (
    .clk_25_2m(clk), .reset(reset), .enable(enable), .pattern_sel(pattern_sel),
    .pclk(pclk_a), .vsync(vsync_a), .href(href_a), .data(data_a),
    .frame_done(fd_a), .frame_cnt(fc_a));

  ov_7670_stream_gen #(.H_ACTIVE(16), .H_BLANK(2), .V_ACTIVE(16), .VSYNC_LINES(1),
                       .V_BACK(1), .V_FRONT(1)) u_b (
    .clk_25_2m(clk), .reset(reset), .enable(enable), .pattern_sel(pattern_sel),
    .pclk(pclk_b), .vsync(vsync_b), .href(href_b), .data(data_b),
    .frame_done(fd_b), .frame_cnt(fc_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: run exceeded time limit, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  // frame_done pulse count and width monitor (instance A)
  int fd_cnt_a = 0;
  int fd_long  = 0;
  bit fd_prev  = 0;
  always @(negedge clk) begin
    if (fd_a) fd_cnt_a++;
    if (fd_a && fd_prev) fd_long++;
    fd_prev = fd_a;
  end

  bit         vs_s [0:799];
  bit         hr_s [0:799];
  logic [7:0] dt_s [0:799];

  logic [7:0] BARS [0:15] = '{8'hFF, 8'hFF, 8'hFF, 8'hE0, 8'h07, 8'hFF, 8'h07, 8'hE0,
                              8'hF8, 8'h1F, 8'hF8, 8'h00, 8'h00, 8'h1F, 8'h00, 8'h00};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic rec_a(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge pclk_a); #1;
      vs_s[i] = vsync_a; hr_s[i] = href_a; dt_s[i] = data_a;
    end
  endtask

  task automatic rec_b(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge pclk_b); #1;
      vs_s[i] = vsync_b; hr_s[i] = href_b; dt_s[i] = data_b;
    end
  endtask

  function automatic int find_s0(input int n);
    for (int i = 0; i < n; i++) if (vs_s[i]) return i;
    return -1;
  endfunction

  // expected colour-bar byte k of line y in frame f (instance A)
  function automatic logic [7:0] bar_byte(input int k, input int y, input int f);
`ifdef OV_GEN_ROW_TAG_EN
    logic [15:0] t;
    t = {f[5:0], y[9:0]};
    if (k == 0) return t[15:8];
    if (k == 1) return t[7:0];
`endif
    return BARS[k];
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int s0, base, cnt, cnt2, idx, ln, k;
    bit ev, eh;
    logic [7:0] ed;
    logic prev;

    reset = 1'b0; enable = 1'b0; pattern_sel = 2'd0;
    repeat (3) @(negedge clk);
    chk("rst_pclk",  pclk_a,  1'b0);
    chk("rst_vsync", vsync_a, 1'b0);
    chk("rst_href",  href_a,  1'b0);
    chk("rst_data",  data_a,  8'h00);
    chk("rst_fd",    fd_a,    1'b0);
    chk("rst_fcnt",  fc_a,    16'h0);
    chk("rst_fcnt_b", fc_b,   16'h0);

    // colour bars on A, two frames
    pattern_sel = 2'd1; enable = 1'b1; reset = 1'b1;
    base = fd_cnt_a;
    rec_a(260);
    s0 = find_s0(260);
    chk("bars_s0", s0, 1);
    if (s0 < 0) s0 = 1;
    for (int f = 0; f < 2; f++)
      for (int i = 0; i < 120; i++) begin
        idx = s0 + 120*f + i; ln = i / 20; k = i % 20;
        ev = (ln == 0);
        eh = (ln >= 2) && (ln <= 4) && (k < 16);
        ed = eh ? bar_byte(k, ln - 2, f) : 8'h00;
        chk($sformatf("bars_vs_f%0d_i%0d", f, i), vs_s[idx], ev);
        chk($sformatf("bars_hr_f%0d_i%0d", f, i), hr_s[idx], eh);
        chk($sformatf("bars_dt_f%0d_i%0d", f, i), dt_s[idx], ed);
      end
    chk("bars_fd_cnt", fd_cnt_a - base, 2);
    chk("bars_fcnt",   fc_a, 16'd2);

    // solid pattern, enable dropped during active line y=2
    do_reset();
    pattern_sel = 2'd0; enable = 1'b1; reset = 1'b1;
    cnt = 0;
    do begin rec_a(1); cnt++; end while (!vs_s[0] && cnt < 400);
    chk("drop_vs_seen", vs_s[0], 1'b1);
    pattern_sel = 2'd3;
    rec_a(85);
    chk("drop_href_mid", hr_s[84], 1'b1);
    enable = 1'b0;
    base = fd_cnt_a;
    rec_a(200);
    chk("drop_solid_hi", dt_s[0], 8'hF8);
    chk("drop_solid_lo", dt_s[1], 8'h00);
    cnt = 0; cnt2 = 0;
    for (int i = 0; i < 200; i++) begin
      if (vs_s[i]) cnt++;
      if (hr_s[i]) cnt2++;
    end
    chk("drop_vs_count",   cnt,  0);
    chk("drop_href_count", cnt2, 10);
    chk("drop_fd_cnt", fd_cnt_a - base, 1);
    chk("drop_fcnt",   fc_a, 16'd1);
    @(negedge clk); prev = pclk_a; cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (pclk_a != prev) cnt++;
      prev = pclk_a;
    end
    chk("idle_pclk_toggles", cnt, 20);
    rec_a(1);
    chk("idle_vsync", vs_s[0], 1'b0);
    chk("idle_href",  hr_s[0], 1'b0);
    enable = 1'b1;
    rec_a(1);
    chk("reenable_vsync", vs_s[0], 1'b1);

    // checkerboard on B
    do_reset();
    pattern_sel = 2'd3; enable = 1'b1; reset = 1'b1;
    rec_b(700);
    s0 = find_s0(700);
    chk("chk_s0", s0, 1);
    if (s0 < 0) s0 = 1;
    chk("chk_p0_0_hi", dt_s[s0+72],     8'h00);
    chk("chk_p0_0_lo", dt_s[s0+73],     8'h00);
    chk("chk_p8_0_hi", dt_s[s0+88],     8'hFF);
    chk("chk_p8_0_lo", dt_s[s0+89],     8'hFF);
    chk("chk_p8_8_hi", dt_s[s0+376],    8'h00);
    chk("chk_p8_8_lo", dt_s[s0+377],    8'h00);
    cnt = 0; cnt2 = 0;
    for (int i = s0; i < s0 + 684; i++) begin
      if (hr_s[i]) cnt++;
      if (vs_s[i]) cnt2++;
    end
    chk("chk_href_count",  cnt,  512);
    chk("chk_vsync_count", cnt2, 36);
    cnt = 0;
    for (int i = 0; i < 700; i++) if (!hr_s[i] && dt_s[i] != 8'h00) cnt++;
    chk("chk_data_blank", cnt, 0);

    // reset during active region of B
    cnt = 0;
    do begin rec_b(1); cnt++; end while (!hr_s[0] && cnt < 800);
    chk("rst_mid_href_seen", hr_s[0], 1'b1);
    chk("rst_mid_fcnt_before", fc_b, 16'd1);
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    chk("rst_mid_href",  href_b,  1'b0);
    chk("rst_mid_vsync", vsync_b, 1'b0);
    chk("rst_mid_data",  data_b,  8'h00);
    chk("rst_mid_pclk",  pclk_b,  1'b0);
    chk("rst_mid_fcnt",  fc_b,    16'd0);
    @(negedge clk); reset = 1'b1;
    rec_b(2);
    chk("restart_s0_vs", vs_s[0], 1'b0);
    chk("restart_s1_vs", vs_s[1], 1'b1);

    // gradient on B, first frame (frame_cnt = 0)
    do_reset();
    pattern_sel = 2'd2; enable = 1'b1; reset = 1'b1;
    rec_b(200);
    s0 = find_s0(200);
    chk("grad_s0", s0, 1);
    if (s0 < 0) s0 = 1;
    chk("grad_p2_1_hi", dt_s[s0+112], 8'h10);
    chk("grad_p2_1_lo", dt_s[s0+113], 8'h20);
    chk("grad_p5_3_hi", dt_s[s0+190], 8'h28);
    chk("grad_p5_3_lo", dt_s[s0+191], 8'h60);

    chk("fd_pulse_width", fd_long, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
